// File: rtl/uart_hex_pkg.sv
// Shared types and constants for the UART hex receive parser.
package uart_hex_pkg;

    // Parser states
    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        OUT     = 2'd2
    } state_e;

    // Error cause reported on err_code, held until the next error
    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_CHAR   = 2'd1,
        ERR_INCOMPLETE = 2'd2,
        ERR_OVERRUN    = 2'd3
    } err_code_e;

    localparam logic [7:0] CHAR_LF    = 8'd10;
    localparam logic [7:0] CHAR_CR    = 8'd13;
    localparam logic [7:0] CHAR_SPACE = 8'd32;

endpackage

// File: rtl/uart_hex_rx_parser_if.sv
// Character-in / byte-out bundle of the hex parser.
// master: character source and byte consumer; slave: the parser.
interface uart_hex_rx_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       eol;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output rx_valid, rx_data, byte_ready,
        input  byte_data, byte_valid, eol, err, err_code
    );

    modport slave (
        input  rx_valid, rx_data, byte_ready,
        output byte_data, byte_valid, eol, err, err_code
    );
endinterface

// File: rtl/ascii_to_nibble.sv
// Combinational ASCII hex digit decoder.
// Macro HEX_LOWERCASE_EN additionally accepts 'a'-'f'.
module ascii_to_nibble (
    input  logic [7:0] ascii_i,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Decode '0'-'9' and 'A'-'F' (optionally 'a'-'f'); letters sit at xxx0001..0110
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
            nibble = ascii_i[3:0];
            is_hex = 1'b1;
        end else if (ascii_i >= 8'h41 && ascii_i <= 8'h46) begin
            nibble = ascii_i[3:0] + 4'd9;
            is_hex = 1'b1;
        end
`ifdef HEX_LOWERCASE_EN
        else if (ascii_i >= 8'h61 && ascii_i <= 8'h66) begin
            nibble = ascii_i[3:0] + 4'd9;
            is_hex = 1'b1;
        end
`else
        else begin
            is_hex = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/uart_hex_rx_parser.sv
// Assembles pairs of ASCII hex characters from a UART receiver into bytes,
// with a valid/ready output handshake, end-of-line pulses and error reporting.
// Macro HEX_LOWERCASE_EN (via ascii_to_nibble) enables lowercase hex digits.
module uart_hex_rx_parser
    import uart_hex_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
    input logic                 CLK,
    input logic                 RST,
    uart_hex_rx_parser_if.slave bus
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            eol_q, eol_d;
    logic            err_q, err_d;
    err_code_e       code_q, code_d;

    logic [3:0] nib;
    logic       is_hex;
    logic       is_term;
    logic       is_space;
    logic       hi_char;

    ascii_to_nibble u_nib (
        .ascii_i (bus.rx_data),
        .nibble  (nib),
        .is_hex  (is_hex)
    );

    assign is_term  = (bus.rx_data == CHAR_CR) || (bus.rx_data == CHAR_LF);
    assign is_space = (bus.rx_data == CHAR_SPACE);

    // Next-state logic; a char accepted alongside a handshake in OUT is
    // handled by the same high-nibble path as in WAIT_HI.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        eol_d   = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        hi_char = 1'b0;

        unique case (state_q)
            WAIT_HI: hi_char = bus.rx_valid;
            WAIT_LO: begin
                if (bus.rx_valid) begin
                    if (is_hex) begin
                        data_d  = {data_q[7:4], nib};
                        state_d = OUT;
                    end else begin
                        err_d   = 1'b1;
                        if (is_term || is_space) begin
                            code_d = ERR_INCOMPLETE;
                        end else begin
                            code_d = ERR_BAD_CHAR;
                        end
                        data_d  = 8'h00;
                        state_d = WAIT_HI;
                    end
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    code_d  = ERR_INCOMPLETE;
                    data_d  = 8'h00;
                    state_d = WAIT_HI;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            OUT: begin
                if (bus.byte_ready) begin
                    state_d = WAIT_HI;
                    hi_char = bus.rx_valid;
                end else if (bus.rx_valid) begin
                    // Consumer is stalled: drop the char, keep the held byte
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: state_d = WAIT_HI;
        endcase

        if (hi_char) begin
            if (is_hex) begin
                data_d  = {nib, 4'h0};
                cnt_d   = '0;
                state_d = WAIT_LO;
            end else if (is_term) begin
                eol_d = 1'b1;
            end else if (!is_space) begin
                err_d  = 1'b1;
                code_d = ERR_BAD_CHAR;
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= WAIT_HI;
            data_q  <= 8'h00;
            cnt_q   <= '0;
            eol_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            eol_q   <= eol_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.byte_data  = data_q;
    assign bus.byte_valid = (state_q == OUT);
    assign bus.eol        = eol_q;
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;

endmodule
